// File: rtl/immgen_pipe.sv
// immgen_pipe: pipelined RV32I/RV64I immediate generator.
//
// One 32-bit instruction per cycle enters over a valid/ready handshake. The
// block decodes the format, builds the sign-extended immediate at XLEN width
// and passes it on with a format code, an illegal flag and a sideband tag.
//
// Buffering is a 2-entry elastic buffer made of an output register and a skid
// register. in_ready comes straight from a flop, so it has no combinational
// path from out_ready.
//
// Optional feature macro: IMMGEN_CSR_EN
//   defined   : csrrwi/csrrsi/csrrci decode as fmt 6 (Z), imm = zext(rs1 field)
//   undefined : those instructions decode as ordinary I-type
module immgen_pipe #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_fmt,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  // Major opcodes (instr[6:0]).
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_IMM_32   = 7'b0011011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_OP_32    = 7'b0111011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

  // Format codes as presented on out_fmt.
  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_Z   = 3'd6;
  localparam logic [2:0] FMT_ILL = 3'd7;

  // Decoded result packed as {illegal, fmt[2:0], imm[XLEN-1:0]}.
  localparam int unsigned DEC_W = XLEN + 4;

  // Immediates are built at 64 bits and truncated to XLEN afterwards, which
  // avoids zero-width replications when XLEN is 32.
  function automatic logic [63:0] imm_i_f(input logic [31:0] instr);
    return {{52{instr[31]}}, instr[31:20]};
  endfunction

  function automatic logic [63:0] imm_s_f(input logic [31:0] instr);
    return {{52{instr[31]}}, instr[31:25], instr[11:7]};
  endfunction

  function automatic logic [63:0] imm_b_f(input logic [31:0] instr);
    return {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  endfunction

  function automatic logic [63:0] imm_u_f(input logic [31:0] instr);
    return {{32{instr[31]}}, instr[31:12], 12'h000};
  endfunction

  function automatic logic [63:0] imm_j_f(input logic [31:0] instr);
    return {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

  // Full decode of one instruction word into {illegal, fmt, imm}.
  function automatic logic [DEC_W-1:0] decode_f(input logic [31:0] instr);
    logic [63:0] imm_w;
    logic [2:0]  fmt;
    logic        ill;
    imm_w = 64'd0;
    fmt   = FMT_ILL;
    ill   = 1'b1;
    if (instr[1:0] == 2'b11) begin
      case (instr[6:0])
        OP_LOAD, OP_MISC_MEM, OP_IMM, OP_JALR: begin
          imm_w = imm_i_f(instr);
          fmt   = FMT_I;
          ill   = 1'b0;
        end
        OP_SYSTEM: begin
`ifdef IMMGEN_CSR_EN
          // funct3[2] selects the immediate CSR forms; rs1 carries a uimm.
          if (instr[14]) begin
            imm_w = {59'd0, instr[19:15]};
            fmt   = FMT_Z;
          end else begin
            imm_w = imm_i_f(instr);
            fmt   = FMT_I;
          end
`else
          imm_w = imm_i_f(instr);
          fmt   = FMT_I;
`endif
          ill = 1'b0;
        end
        OP_STORE: begin
          imm_w = imm_s_f(instr);
          fmt   = FMT_S;
          ill   = 1'b0;
        end
        OP_BRANCH: begin
          imm_w = imm_b_f(instr);
          fmt   = FMT_B;
          ill   = 1'b0;
        end
        OP_LUI, OP_AUIPC: begin
          imm_w = imm_u_f(instr);
          fmt   = FMT_U;
          ill   = 1'b0;
        end
        OP_JAL: begin
          imm_w = imm_j_f(instr);
          fmt   = FMT_J;
          ill   = 1'b0;
        end
        OP_OP: begin
          imm_w = 64'd0;
          fmt   = FMT_R;
          ill   = 1'b0;
        end
        OP_IMM_32: begin
          // Word-sized immediate ops exist only on RV64.
          if (XLEN == 64) begin
            imm_w = imm_i_f(instr);
            fmt   = FMT_I;
            ill   = 1'b0;
          end else begin
            imm_w = 64'd0;
            fmt   = FMT_ILL;
            ill   = 1'b1;
          end
        end
        OP_OP_32: begin
          if (XLEN == 64) begin
            imm_w = 64'd0;
            fmt   = FMT_R;
            ill   = 1'b0;
          end else begin
            imm_w = 64'd0;
            fmt   = FMT_ILL;
            ill   = 1'b1;
          end
        end
        default: begin
          imm_w = 64'd0;
          fmt   = FMT_ILL;
          ill   = 1'b1;
        end
      endcase
    end else begin
      // Compressed or reserved encodings are not handled here.
      imm_w = 64'd0;
      fmt   = FMT_ILL;
      ill   = 1'b1;
    end
    return {ill, fmt, imm_w[XLEN-1:0]};
  endfunction

  // Output register entry.
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_imm_q,   out_imm_d;
  logic [2:0]       out_fmt_q,   out_fmt_d;
  logic             out_ill_q,   out_ill_d;
  logic [TAG_W-1:0] out_tag_q,   out_tag_d;

  // Skid register entry.
  logic             skid_valid_q, skid_valid_d;
  logic [XLEN-1:0]  skid_imm_q,   skid_imm_d;
  logic [2:0]       skid_fmt_q,   skid_fmt_d;
  logic             skid_ill_q,   skid_ill_d;
  logic [TAG_W-1:0] skid_tag_q,   skid_tag_d;

  // Registered copy of !skid_valid so in_ready leaves a flop directly.
  logic             in_ready_q,   in_ready_d;

  logic [DEC_W-1:0] dec_s;
  logic [XLEN-1:0]  dec_imm_s;
  logic [2:0]       dec_fmt_s;
  logic             dec_ill_s;
  logic             in_fire_s;
  logic             out_fire_s;

  // Decode the incoming word and detect handshake transfers.
  always_comb begin
    dec_s      = decode_f(in_instr);
    dec_imm_s  = dec_s[XLEN-1:0];
    dec_fmt_s  = dec_s[XLEN+2:XLEN];
    dec_ill_s  = dec_s[XLEN+3];
    in_fire_s  = in_valid & in_ready_q;
    out_fire_s = out_valid_q & out_ready;
  end

  // Elastic buffer next state: output register refills from skid first,
  // then from the decoder; a stalled output diverts new input into skid.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_imm_d    = out_imm_q;
    out_fmt_d    = out_fmt_q;
    out_ill_d    = out_ill_q;
    out_tag_d    = out_tag_q;
    skid_valid_d = skid_valid_q;
    skid_imm_d   = skid_imm_q;
    skid_fmt_d   = skid_fmt_q;
    skid_ill_d   = skid_ill_q;
    skid_tag_d   = skid_tag_q;
    if (!out_valid_q || out_fire_s) begin
      if (skid_valid_q) begin
        // Older entry in skid goes first; input is blocked while skid is full.
        out_valid_d  = 1'b1;
        out_imm_d    = skid_imm_q;
        out_fmt_d    = skid_fmt_q;
        out_ill_d    = skid_ill_q;
        out_tag_d    = skid_tag_q;
        skid_valid_d = 1'b0;
      end else if (in_fire_s) begin
        out_valid_d = 1'b1;
        out_imm_d   = dec_imm_s;
        out_fmt_d   = dec_fmt_s;
        out_ill_d   = dec_ill_s;
        out_tag_d   = in_tag;
      end else begin
        out_valid_d = 1'b0;
      end
    end else begin
      // Output is stalled and holds; a newly accepted word parks in skid.
      if (in_fire_s) begin
        skid_valid_d = 1'b1;
        skid_imm_d   = dec_imm_s;
        skid_fmt_d   = dec_fmt_s;
        skid_ill_d   = dec_ill_s;
        skid_tag_d   = in_tag;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
    in_ready_d = ~skid_valid_d;
  end

  // State flops; reset discards both entries and opens the input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q  <= 1'b0;
      out_imm_q    <= '0;
      out_fmt_q    <= 3'd0;
      out_ill_q    <= 1'b0;
      out_tag_q    <= '0;
      skid_valid_q <= 1'b0;
      skid_imm_q   <= '0;
      skid_fmt_q   <= 3'd0;
      skid_ill_q   <= 1'b0;
      skid_tag_q   <= '0;
      in_ready_q   <= 1'b1;
    end else begin
      out_valid_q  <= out_valid_d;
      out_imm_q    <= out_imm_d;
      out_fmt_q    <= out_fmt_d;
      out_ill_q    <= out_ill_d;
      out_tag_q    <= out_tag_d;
      skid_valid_q <= skid_valid_d;
      skid_imm_q   <= skid_imm_d;
      skid_fmt_q   <= skid_fmt_d;
      skid_ill_q   <= skid_ill_d;
      skid_tag_q   <= skid_tag_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_imm     = out_imm_q;
  assign out_fmt     = out_fmt_q;
  assign out_illegal = out_ill_q;
  assign out_tag     = out_tag_q;

endmodule

// File: tb/tb_immgen_pipe.sv
// Directed bench for immgen_pipe: one XLEN=32 and one XLEN=64 instance share
// the input stream; expected values are hand-computed from the ISA encodings.
module tb_immgen_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [3:0]  in_tag;
  logic        out_ready;

  logic        in_ready32, out_valid32, out_illegal32;
  logic [31:0] out_imm32;
  logic [2:0]  out_fmt32;
  logic [3:0]  out_tag32;

  logic        in_ready64, out_valid64, out_illegal64;
  logic [63:0] out_imm64;
  logic [2:0]  out_fmt64;
  logic [3:0]  out_tag64;

  int checks;
  int failures;

  immgen_pipe #(.XLEN(32), .TAG_W(4)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_fmt(out_fmt32),
    .out_illegal(out_illegal32), .out_tag(out_tag32)
  );

  immgen_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready64),
    .in_instr(in_instr), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready),
    .out_imm(out_imm64), .out_fmt(out_fmt64),
    .out_illegal(out_illegal64), .out_tag(out_tag64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      failures = failures + 1;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  logic [31:0] stream_instr [5];
  logic [31:0] stream_imm   [5];
  logic [2:0]  stream_fmt   [5];

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0000_0000;
    in_tag    = 4'd0;
    out_ready = 1'b1;

    stream_instr[0] = 32'h00A00093; stream_imm[0] = 32'd10;         stream_fmt[0] = 3'd1;
    stream_instr[1] = 32'h00112423; stream_imm[1] = 32'd8;          stream_fmt[1] = 3'd2;
    stream_instr[2] = 32'hFE208EE3; stream_imm[2] = 32'hFFFFFFFC;   stream_fmt[2] = 3'd3;
    stream_instr[3] = 32'h123450B7; stream_imm[3] = 32'h12345000;   stream_fmt[3] = 3'd4;
    stream_instr[4] = 32'h010000EF; stream_imm[4] = 32'd16;         stream_fmt[4] = 3'd5;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {63'd0, out_valid32}, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready32}, 64'd1);
    chk("rst_out_imm", {32'd0, out_imm32}, 64'd0);
    chk("rst_out_fmt", {61'd0, out_fmt32}, 64'd0);
    chk("rst_out_illegal", {63'd0, out_illegal32}, 64'd0);
    chk("rst_out_tag", {60'd0, out_tag32}, 64'd0);
    rst_n = 1'b1;

    // Back-to-back stream with out_ready=1: result i visible one cycle later.
    for (int i = 0; i <= 5; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("stream_valid", {63'd0, out_valid32}, 64'd1);
        chk("stream_imm", {32'd0, out_imm32}, {32'd0, stream_imm[i-1]});
        chk("stream_fmt", {61'd0, out_fmt32}, {61'd0, stream_fmt[i-1]});
        chk("stream_tag", {60'd0, out_tag32}, 64'(i - 1));
      end
      if (i < 5) begin
        in_valid = 1'b1;
        in_instr = stream_instr[i];
        in_tag   = 4'(i);
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    chk("stream_drained", {63'd0, out_valid32}, 64'd0);

    // Backpressure: tags 1,2,3 with out_ready held low.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = 32'h00A00093;
    in_tag    = 4'd1;
    @(negedge clk);
    chk("bp_tag1_out", {60'd0, out_tag32}, 64'd1);
    chk("bp_ready_after1", {63'd0, in_ready32}, 64'd1);
    in_tag   = 4'd2;
    in_instr = 32'h00112423;
    @(negedge clk);
    chk("bp_ready_full", {63'd0, in_ready32}, 64'd0);
    chk("bp_hold_tag", {60'd0, out_tag32}, 64'd1);
    in_tag   = 4'd3;
    in_instr = 32'h010000EF;
    @(negedge clk);
    chk("bp_ready_waiting", {63'd0, in_ready32}, 64'd0);
    chk("bp_stable_tag", {60'd0, out_tag32}, 64'd1);
    chk("bp_stable_imm", {32'd0, out_imm32}, 64'd10);
    chk("bp_stable_fmt", {61'd0, out_fmt32}, 64'd1);
    chk("bp_stable_valid", {63'd0, out_valid32}, 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_out_tag2", {60'd0, out_tag32}, 64'd2);
    chk("bp_out_imm2", {32'd0, out_imm32}, 64'd8);
    chk("bp_ready_reopen", {63'd0, in_ready32}, 64'd1);
    @(negedge clk);
    chk("bp_out_tag3", {60'd0, out_tag32}, 64'd3);
    chk("bp_out_imm3", {32'd0, out_imm32}, 64'd16);
    chk("bp_out_valid3", {63'd0, out_valid32}, 64'd1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("bp_drained", {63'd0, out_valid32}, 64'd0);

    // XLEN comparison: LUI with bit 31 set, then addiw.
    in_valid = 1'b1;
    in_instr = 32'h800000B7;
    @(negedge clk);
    chk("lui64_imm", out_imm64, 64'hFFFFFFFF80000000);
    chk("lui64_fmt", {61'd0, out_fmt64}, 64'd4);
    chk("lui32_imm", {32'd0, out_imm32}, 64'h80000000);
    in_instr = 32'h0050009B;
    @(negedge clk);
    chk("addiw64_imm", out_imm64, 64'd5);
    chk("addiw64_fmt", {61'd0, out_fmt64}, 64'd1);
    chk("addiw64_ill", {63'd0, out_illegal64}, 64'd0);
    chk("addiw32_fmt", {61'd0, out_fmt32}, 64'd7);
    chk("addiw32_ill", {63'd0, out_illegal32}, 64'd1);
    chk("addiw32_imm", {32'd0, out_imm32}, 64'd0);

    // Illegal encodings.
    in_instr = 32'h00000000;
    @(negedge clk);
    chk("ill0_fmt", {61'd0, out_fmt32}, 64'd7);
    chk("ill0_ill", {63'd0, out_illegal32}, 64'd1);
    chk("ill0_imm", {32'd0, out_imm32}, 64'd0);
    in_instr = 32'hFFFFFFFF;
    @(negedge clk);
    chk("illF_fmt", {61'd0, out_fmt32}, 64'd7);
    chk("illF_ill", {63'd0, out_illegal32}, 64'd1);
    chk("illF_imm", {32'd0, out_imm32}, 64'd0);
    chk("illF64_imm", out_imm64, 64'd0);

    // csrrwi x1, 0x300, 5.
    in_instr = 32'h3002D0F3;
    @(negedge clk);
`ifdef IMMGEN_CSR_EN
    chk("csr_fmt", {61'd0, out_fmt32}, 64'd6);
    chk("csr_imm", {32'd0, out_imm32}, 64'd5);
`else
    chk("csr_fmt", {61'd0, out_fmt32}, 64'd1);
    chk("csr_imm", {32'd0, out_imm32}, 64'd768);
`endif
    chk("csr_ill", {63'd0, out_illegal32}, 64'd0);

    // Fill both entries, then assert reset between clock edges.
    out_ready = 1'b0;
    in_instr  = 32'h00112423;
    in_tag    = 4'd7;
    @(negedge clk);
    in_tag = 4'd8;
    @(negedge clk);
    in_valid = 1'b0;
    chk("mid_full_ready", {63'd0, in_ready32}, 64'd0);
    chk("mid_full_valid", {63'd0, out_valid32}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, out_valid32}, 64'd0);
    chk("mid_rst_ready", {63'd0, in_ready32}, 64'd1);
    chk("mid_rst_valid64", {63'd0, out_valid64}, 64'd0);
    out_ready = 1'b1;
    @(negedge clk);
    rst_n    = 1'b1;
    in_valid = 1'b1;
    in_instr = 32'h00A00093;
    in_tag   = 4'd5;
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_valid", {63'd0, out_valid32}, 64'd1);
    chk("post_rst_imm", {32'd0, out_imm32}, 64'd10);
    chk("post_rst_tag", {60'd0, out_tag32}, 64'd5);
    @(negedge clk);
    chk("post_rst_single", {63'd0, out_valid32}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/immgen_pipe.md
Name: immgen_pipe

Overview:
- Pipelined, parametrised immediate generator for the next-generation RV32I/RV64I core.
- Accepts one 32-bit instruction per cycle over a valid/ready handshake and decodes its format.
- Produces the sign-extended immediate at XLEN width, a format code, an illegal-opcode flag and a pass-through tag.
- Contains a 2-entry elastic buffer (output register plus skid register), so upstream decode is decoupled from execute stalls.

Parameters:
- XLEN, 32, datapath width; legal values are 32 or 64.
- TAG_W, 4, width of the sideband tag carried with each instruction (e.g. ROB/PC index).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  block can accept an instruction this cycle.
- in_instr  in  32  raw instruction word.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_imm  out  XLEN  decoded immediate.
- out_fmt  out  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=Z, 7=illegal.
- out_illegal  out  1  opcode not recognised.
- out_tag  out  TAG_W  tag of the current result.

Behaviour:
- Reset (async assert, sync deassert): out_valid=0, skid_valid=0, out_imm=0, out_fmt=0, out_illegal=0, out_tag=0.
- in_ready = !skid_valid, driven directly from a flop with no combinational path from out_ready. It is 1 while in reset.
- Transfers:
  - Input transfer occurs when in_valid && in_ready.
  - Output transfer occurs when out_valid && out_ready.
- Latency: an instruction accepted in cycle N appears on out_* in cycle N+1 if the output register is empty or draining.
- Throughput: 1 instruction per cycle while out_ready=1.
- Input accepted while out_valid && !out_ready: the decoded result goes to the skid register, skid_valid=1, and in_ready falls the next cycle.
- Output transfer with skid_valid=1: the skid contents move to the output register, and skid_valid=0.
- Simultaneous input and output transfer with skid empty: the output register loads the new result with no bubble.
- While out_valid && !out_ready, out_imm, out_fmt, out_illegal and out_tag hold stable.
- Ordering is strictly FIFO. No instruction is dropped or duplicated.
- Decode (combinational before the register):
  - in_instr[1:0] != 2'b11 means illegal.
  - 0000011, 0001111, 0010011, 1100111 and 1110011 are I-type: imm = sext(instr[31:20]).
  - 0100011 is S-type: imm = sext({instr[31:25], instr[11:7]}).
  - 1100011 is B-type: imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 0110111 and 0010111 are U-type: imm = sext({instr[31:12], 12'b0}) to XLEN.
  - 1101111 is J-type: imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - 0110011 is R-type: imm = 0.
  - XLEN=64 only: 0011011 is I-type and 0111011 is R-type. With XLEN=32 these two opcodes are illegal.
  - Any other opcode: fmt=7, out_illegal=1, imm=0.
- All sign extension is to the full XLEN from the top bit of the immediate field.
- Reset asserted mid-stream: both entries are discarded immediately. The first post-reset accept is a fresh result.

Optional Feature:
- Macro IMMGEN_CSR_EN.
- Defined: SYSTEM opcode with funct3[2]=1 (csrrwi/csrrsi/csrrci) gives fmt=6 (Z) and imm = zext(instr[19:15]).
- Undefined: those instructions decode as I-type, imm = sext(instr[31:20]), and fmt 6 is never produced.

Test Plan:
- XLEN=32, out_ready=1, back-to-back stream 0x00A00093, 0x00112423, 0xFE208EE3, 0x123450B7, 0x010000EF -> one cycle later, consecutive results:
  - imm 10 fmt 1
  - imm 8 fmt 2
  - imm 0xFFFFFFFC fmt 3
  - imm 0x12345000 fmt 4
  - imm 16 fmt 5
- Backpressure: hold out_ready=0, send tags 1,2,3 -> tags 1 and 2 accepted, in_ready=0 while tag 3 is waiting. Release out_ready -> outputs tag 1, 2, 3 in order, outputs stable while stalled.
- XLEN=64: 0x800000B7 -> imm 0xFFFFFFFF80000000. 0x0050009B (addiw) -> imm 5 fmt 1. The same addiw with XLEN=32 -> fmt 7, out_illegal=1.
- Illegal: 0x00000000 and 0xFFFFFFFF -> fmt 7, out_illegal=1, imm 0.
- 0x3002D0F3 (csrrwi x1,0x300,5):
  - with IMMGEN_CSR_EN -> fmt 6 imm 5.
  - without -> fmt 1 imm 768.
- Assert rst_n low with both entries full -> out_valid=0 and in_ready=1 asynchronously. After release, 0x00A00093 -> imm 10 after 1 cycle.
